// File: rtl/store_monitor_pkg.sv
// Shared types and default verdict constants for the store monitor and
// the processor-level bench that drives it.
package store_monitor_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } store_rec_t;

    localparam logic [31:0] DEFAULT_PASS_ADDR   = 32'd84;
    localparam logic [31:0] DEFAULT_PASS_DATA   = 32'd7;
    localparam logic [31:0] DEFAULT_IGNORE_ADDR = 32'd80;

endpackage

// File: rtl/store_monitor_if.sv
// Store stream from the processor write port plus the show-ahead drain
// handshake; the monitor sits on the slave side.
interface store_monitor_if;

    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;

    modport master (
        output memwrite, dataadr, writedata, out_ready,
        input  out_valid, out_addr, out_data
    );

    modport slave (
        input  memwrite, dataadr, writedata, out_ready,
        output out_valid, out_addr, out_data
    );

endinterface

// File: rtl/store_monitor_sync_fifo.sv
// Single-clock show-ahead FIFO; full/empty derive from the occupancy count
// so the pointers can wrap freely at their natural width.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wr_data,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign o_full    = (r_level == LW'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    // NOTE: storage has no reset; validity is tracked by r_level, and the read
    // mux forces zero while empty so nothing stale leaks out after reset.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/store_monitor.sv
// Watches the processor store stream, buffers every store for a drain port
// and latches a sticky pass/fail verdict from the first deciding store.
module store_monitor
    import store_monitor_pkg::*;
#(
    parameter int          DEPTH       = 8,
    parameter logic [31:0] PASS_ADDR   = DEFAULT_PASS_ADDR,
    parameter logic [31:0] PASS_DATA   = DEFAULT_PASS_DATA,
    parameter logic [31:0] IGNORE_ADDR = DEFAULT_IGNORE_ADDR
) (
    input  logic                   clk,
    input  logic                   reset,
    store_monitor_if.slave         bus,
    output logic [$clog2(DEPTH):0] level,
    output logic [7:0]             overflow_cnt,
    output logic                   done,
    output logic                   pass,
    output logic                   fail
);

    state_t     r_state;
    logic       r_done;
    logic       r_pass;
    logic       r_fail;
    logic [7:0] r_ovf_cnt;

    store_rec_t w_push_rec;
    store_rec_t w_head_rec;
    logic       w_full;
    logic       w_empty;
    logic       w_valid;
    logic       w_pop;
    logic       w_drop;
    logic       w_is_pass;
    logic       w_is_ignore;

    assign w_push_rec  = '{addr: bus.dataadr, data: bus.writedata};
    assign w_valid     = !w_empty;
    assign w_pop       = w_valid && bus.out_ready;
    assign w_drop      = bus.memwrite && w_full && !w_pop;
    assign w_is_pass   = (bus.dataadr == PASS_ADDR) && (bus.writedata == PASS_DATA);
    assign w_is_ignore = (bus.dataadr == IGNORE_ADDR);

    sync_fifo #(
        .WIDTH ($bits(store_rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (bus.memwrite),
        .i_pop     (w_pop),
        .i_wr_data (w_push_rec),
        .o_rd_data (w_head_rec),
        .o_level   (level),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign bus.out_valid = w_valid;
    assign bus.out_addr  = w_head_rec.addr;
    assign bus.out_data  = w_head_rec.data;

    // Verdict flags are set alongside the state so they leave straight from flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
        end else if ((r_state == ST_RUN) && bus.memwrite) begin
            if (w_is_pass) begin
                r_state <= ST_PASS;
                r_done  <= 1'b1;
                r_pass  <= 1'b1;
            end else if (!w_is_ignore) begin
                r_state <= ST_FAIL;
                r_done  <= 1'b1;
                r_fail  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf_cnt <= '0;
        end else if (w_drop && (r_ovf_cnt != 8'hFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 8'd1;
        end
    end

    assign overflow_cnt = r_ovf_cnt;
    assign done         = r_done;
    assign pass         = r_pass;
    assign fail         = r_fail;

endmodule

// File: tb/tb_store_monitor.sv
// Bench for store_monitor: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_store_monitor;
    import store_monitor_pkg::*;

    localparam int DEPTH  = 8;
    localparam int V_RUN  = 0;
    localparam int V_PASS = 1;
    localparam int V_FAIL = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] level;
    logic [7:0] overflow_cnt;
    logic       done;
    logic       pass;
    logic       fail;

    store_monitor_if bus ();

    store_monitor #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .level        (level),
        .overflow_cnt (overflow_cnt),
        .done         (done),
        .pass         (pass),
        .fail         (fail)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    store_rec_t m_q[$];
    int         m_verdict;
    int         m_ovf;

    typedef struct {
        bit          do_reset;
        bit          mw;
        logic [31:0] a;
        logic [31:0] d;
        bit          rdy;
        int          exp_level;
        logic [31:0] exp_a;
        logic [31:0] exp_d;
        bit          exp_done;
        bit          exp_pass;
        bit          exp_fail;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_verdict = V_RUN;
        m_ovf     = 0;
    endtask

    // Reference behaviour: classify the store, pop if the consumer takes the
    // head, then append or drop depending on the occupancy seen before the edge.
    task automatic model_step();
        int pre;
        bit pop;
        pre = m_q.size();
        pop = (pre > 0) && bus.out_ready;
        if (bus.memwrite && m_verdict == V_RUN) begin
            if (bus.dataadr == 32'd84 && bus.writedata == 32'd7) m_verdict = V_PASS;
            else if (bus.dataadr != 32'd80)                      m_verdict = V_FAIL;
        end
        if (pop) void'(m_q.pop_front());
        if (bus.memwrite) begin
            if (pre < DEPTH || pop) m_q.push_back('{addr: bus.dataadr, data: bus.writedata});
            else if (m_ovf < 255)   m_ovf++;
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, "/level"}, level, m_q.size());
        check({tag, "/valid"}, bus.out_valid, m_q.size() > 0);
        if (m_q.size() > 0)
            check({tag, "/head"}, {bus.out_addr, bus.out_data}, {m_q[0].addr, m_q[0].data});
        check({tag, "/ovf"}, overflow_cnt, m_ovf);
        check({tag, "/verdict"}, {done, pass, fail},
              {m_verdict != V_RUN, m_verdict == V_PASS, m_verdict == V_FAIL});
    endtask

    task automatic set_in(input bit mw, input logic [31:0] a, input logic [31:0] d, input bit rdy);
        bus.memwrite  = mw;
        bus.dataadr   = a;
        bus.writedata = d;
        bus.out_ready = rdy;
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_model(tag);
    endtask

    // Called at posedge+1; releases two time units later, well before the next edge.
    task automatic pulse_reset();
        reset = 1'b0;
        model_reset();
        #2;
        reset = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 32'd80, 32'd3, 1'b1, 1, 32'd80, 32'd3, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'd80, 32'd5, 1'b1, 1, 32'd80, 32'd5, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 32'd84, 32'd7, 1'b1, 1, 32'd84, 32'd7, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'd0,  32'd0, 1'b1, 0, 32'd0,  32'd0, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 32'd84, 32'd6, 1'b0, 1, 32'd84, 32'd6, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 32'd84, 32'd7, 1'b0, 2, 32'd84, 32'd6, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 32'd0,  32'd0, 1'b1, 1, 32'd84, 32'd7, 1'b1, 1'b0, 1'b1};

        // Reset then idle
        reset = 1'b0;
        set_in(1'b0, 32'd0, 32'd0, 1'b0);
        model_reset();
        #12;
        check("rst_level", level, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_verdict", {done, pass, fail}, 3'b000);
        #10;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) tick("idle");
        check("idle_ovf", overflow_cnt, 0);

        // Pass and fail sequences from the vector table
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].do_reset) pulse_reset();
            set_in(vecs[i].mw, vecs[i].a, vecs[i].d, vecs[i].rdy);
            model_step();
            @(posedge clk);
            #1;
            check($sformatf("vec%0d/level", i), level, vecs[i].exp_level);
            check($sformatf("vec%0d/verdict", i), {done, pass, fail},
                  {vecs[i].exp_done, vecs[i].exp_pass, vecs[i].exp_fail});
            if (vecs[i].exp_level > 0)
                check($sformatf("vec%0d/head", i), {bus.out_addr, bus.out_data},
                      {vecs[i].exp_a, vecs[i].exp_d});
        end
        set_in(1'b0, 32'd0, 32'd0, 1'b0);

        // Overflow: ten stores into an eight-deep FIFO, then drain
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 32'd80, 32'(i), 1'b0);
            tick("ovf_fill");
        end
        check("ovf_level", level, 8);
        check("ovf_cnt", overflow_cnt, 2);
        set_in(1'b0, 32'd0, 32'd0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check("drain_head", {bus.out_addr, bus.out_data}, {32'd80, 32'(i)});
            tick("drain");
        end
        check("drain_empty", level, 0);

        // Simultaneous push and pop while full
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 32'd80, 32'(100 + i), 1'b0);
            tick("full_fill");
        end
        set_in(1'b1, 32'd80, 32'd200, 1'b1);
        tick("full_pushpop");
        check("full_pp_level", level, 8);
        check("full_pp_ovf", overflow_cnt, 2);
        set_in(1'b0, 32'd0, 32'd0, 1'b1);
        for (int i = 1; i < 8; i++) begin
            check("full_pp_head", {bus.out_addr, bus.out_data}, {32'd80, 32'(100 + i)});
            tick("full_drain");
        end
        check("full_pp_tail", {bus.out_addr, bus.out_data}, {32'd80, 32'd200});

        // Asynchronous reset in the middle of a buffered pass run
        pulse_reset();
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, 32'd80, 32'(i), 1'b0);
            tick("mid_fill");
        end
        set_in(1'b1, 32'd84, 32'd7, 1'b0);
        tick("mid_pass");
        check("mid_pre_level", level, 5);
        check("mid_pre_pass", pass, 1);
        set_in(1'b0, 32'd0, 32'd0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_verdict", {done, pass, fail}, 3'b000);
        model_reset();
        #1;
        reset = 1'b1;

        // Randomized traffic against the reference model
        for (int blk = 0; blk < 10; blk++) begin
            pulse_reset();
            for (int c = 0; c < 200; c++) begin
                int r;
                logic [31:0] a;
                logic [31:0] d;
                r = $urandom_range(0, 99);
                d = $urandom_range(0, 15);
                if (r < 85)      a = 32'd80;
                else if (r < 93) a = 32'd84;
                else             a = 32'($urandom_range(0, 63)) << 2;
                set_in($urandom_range(0, 99) < 60, a, d,
                       $urandom_range(0, 99) < ((blk % 2 != 0) ? 30 : 70));
                tick("rand");
            end
        end
        set_in(1'b0, 32'd0, 32'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
